// File: rtl/regfile_dualwrite_if.sv
// ---------------------------------------------------------------------------
// regfile_dualwrite_if
// Bundle of the core-side signals of the dual-write register file.
//   Write port 0 (ALU writeback)  : WriteEn0, WriteDir0, WriteData0
//   Write port 1 (load writeback) : WriteEn1, WriteDir1, WriteData1
//   Read ports (decode)           : ReadDir0/ReadData0, ReadDir1/ReadData1
//   Control/status                : ClearReq (one-cycle re-zero request),
//                                   Ready (bank valid, writes accepted)
// master = the core side driving addresses/data, slave = the register file.
// ---------------------------------------------------------------------------
interface regfile_dualwrite_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);

   logic            WriteEn0;
   logic [AW-1:0]   WriteDir0;
   logic [XLEN-1:0] WriteData0;
   logic            WriteEn1;
   logic [AW-1:0]   WriteDir1;
   logic [XLEN-1:0] WriteData1;
   logic [AW-1:0]   ReadDir0;
   logic [XLEN-1:0] ReadData0;
   logic [AW-1:0]   ReadDir1;
   logic [XLEN-1:0] ReadData1;
   logic            ClearReq;
   logic            Ready;

   // The core drives writes, read addresses and clear requests.
   modport master (
      output WriteEn0, WriteDir0, WriteData0,
      output WriteEn1, WriteDir1, WriteData1,
      output ReadDir0, ReadDir1, ClearReq,
      input  ReadData0, ReadData1, Ready
   );

   // The register file consumes them and returns read data and readiness.
   modport slave (
      input  WriteEn0, WriteDir0, WriteData0,
      input  WriteEn1, WriteDir1, WriteData1,
      input  ReadDir0, ReadDir1, ClearReq,
      output ReadData0, ReadData1, Ready
   );

endinterface

// File: rtl/regfile_dualwrite.sv
// ---------------------------------------------------------------------------
// regfile_dualwrite
// XLEN-wide, NREGS-deep register file with two synchronous write ports and
// two asynchronous read ports, optional write-to-read bypass and optional
// hardwired-zero register 0. A sequential clear engine zeroes one register
// per cycle after reset or on ClearReq; Ready is high only once the whole
// bank has been cleared.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (restarts the clear, bank untouched)
//   bus  - regfile_dualwrite_if slave modport (write ports, read ports,
//          ClearReq, Ready)
// ---------------------------------------------------------------------------
module regfile_dualwrite #(
   parameter int  XLEN     = 32,
   parameter int  NREGS    = 32,
   parameter int  BYPASS   = 1,
   parameter int  ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input logic                  clk,
   input logic                  rst,
   regfile_dualwrite_if.slave   bus
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   state_e          state_q;
   logic [AW-1:0]   clrCnt_q;
   logic [XLEN-1:0] bank_q [NREGS];

   logic            wrOk0;
   logic            wrOk1;
   logic [AW-1:0]   rdDir  [2];
   logic [XLEN-1:0] rdData [2];

   // Register 0 is only read-only when the hardwired-zero option is on.
   function automatic logic isWritable(input logic [AW-1:0] dir);
      return !((ZERO_REG != 0) && (dir == '0));
   endfunction

   // A write port is live only in RUN, outside reset, and to a writable
   // register; the same qualification gates the bypass path so a dropped
   // write can never be forwarded to a reader.
   always_comb begin
      wrOk0 = (state_q == RUN) && !rst && bus.WriteEn0 && isWritable(bus.WriteDir0);
      wrOk1 = (state_q == RUN) && !rst && bus.WriteEn1 && isWritable(bus.WriteDir1);
   end

   // Clear FSM. Reset parks us in CLEAR at register 0; CLEAR walks the
   // counter across the whole bank and hands over to RUN after the last
   // register. A ClearReq in RUN restarts the walk, while one arriving in
   // CLEAR is ignored so it cannot stretch an ongoing clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CLEAR;
         clrCnt_q <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               clrCnt_q <= clrCnt_q + AW'(1);
               if (clrCnt_q == AW'(NREGS - 1)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (bus.ClearReq) begin
                  state_q  <= CLEAR;
                  clrCnt_q <= '0;
               end
            end
            default: begin
               state_q  <= CLEAR;
               clrCnt_q <= '0;
            end
         endcase
      end
   end

   // Storage. Reset itself never touches the bank; the clear engine zeroes
   // it one register per cycle afterwards. In RUN the port-1 write is issued
   // after port 0, so when both target one register the load data wins.
   // Writes accompanying a ClearReq still land and are wiped by the clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            bank_q[clrCnt_q] <= '0;
         end else begin
            if (wrOk0) begin
               bank_q[bus.WriteDir0] <= bus.WriteData0;
            end
            if (wrOk1) begin
               bank_q[bus.WriteDir1] <= bus.WriteData1;
            end
         end
      end
   end

   assign rdDir[0] = bus.ReadDir0;
   assign rdDir[1] = bus.ReadDir1;

   // Asynchronous read ports. Priority from lowest to highest: stored value,
   // bypass from port 0, bypass from port 1, hardwired zero, and finally
   // forcing zero while the bank is being cleared.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         rdData[k] = bank_q[rdDir[k]];
         if (BYPASS != 0) begin
            if (wrOk0 && (rdDir[k] == bus.WriteDir0)) begin
               rdData[k] = bus.WriteData0;
            end
            if (wrOk1 && (rdDir[k] == bus.WriteDir1)) begin
               rdData[k] = bus.WriteData1;
            end
         end
         if ((ZERO_REG != 0) && (rdDir[k] == '0)) begin
            rdData[k] = '0;
         end
         if (state_q != RUN) begin
            rdData[k] = '0;
         end
      end
   end

   assign bus.ReadData0 = rdData[0];
   assign bus.ReadData1 = rdData[1];

   // Ready is taken straight from the state register, so it is glitch-free.
   assign bus.Ready = (state_q == RUN);

endmodule

// File: tb/tb_regfile_dualwrite.sv
// ---------------------------------------------------------------------------
// tb_regfile_dualwrite
// Drives two register files with identical stimulus: dutA uses bypass and a
// hardwired-zero register 0, dutB has neither. A behavioural model tracks
// the expected bank contents and readiness and every cycle both read ports
// and Ready of both instances are compared against it.
// ---------------------------------------------------------------------------
module tb_regfile_dualwrite;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            we0 = 1'b0;
   logic            we1 = 1'b0;
   logic            clrReq = 1'b0;
   logic [AW-1:0]   wd0 = '0;
   logic [AW-1:0]   wd1 = '0;
   logic [AW-1:0]   rd0 = '0;
   logic [AW-1:0]   rd1 = '0;
   logic [XLEN-1:0] d0 = '0;
   logic [XLEN-1:0] d1 = '0;

   int checkCount = 0;
   int failCount  = 0;

   bit              modelValid = 1'b0;
   bit              modelRunning = 1'b0;
   int              clearLeft = NREGS;
   logic [XLEN-1:0] bankA [NREGS];
   logic [XLEN-1:0] bankB [NREGS];

   // Free-running clock, period 100.
   always #50 clk = ~clk;

   regfile_dualwrite_if #(.XLEN(XLEN), .AW(AW)) ifA ();
   regfile_dualwrite_if #(.XLEN(XLEN), .AW(AW)) ifB ();

   assign ifA.WriteEn0   = we0;
   assign ifA.WriteDir0  = wd0;
   assign ifA.WriteData0 = d0;
   assign ifA.WriteEn1   = we1;
   assign ifA.WriteDir1  = wd1;
   assign ifA.WriteData1 = d1;
   assign ifA.ReadDir0   = rd0;
   assign ifA.ReadDir1   = rd1;
   assign ifA.ClearReq   = clrReq;

   assign ifB.WriteEn0   = we0;
   assign ifB.WriteDir0  = wd0;
   assign ifB.WriteData0 = d0;
   assign ifB.WriteEn1   = we1;
   assign ifB.WriteDir1  = wd1;
   assign ifB.WriteData1 = d1;
   assign ifB.ReadDir0   = rd0;
   assign ifB.ReadDir1   = rd1;
   assign ifB.ClearReq   = clrReq;

   regfile_dualwrite #(
      .XLEN(XLEN), .NREGS(NREGS), .BYPASS(1), .ZERO_REG(1)
   ) dutA (
      .clk(clk),
      .rst(rst),
      .bus(ifA.slave)
   );

   regfile_dualwrite #(
      .XLEN(XLEN), .NREGS(NREGS), .BYPASS(0), .ZERO_REG(0)
   ) dutB (
      .clk(clk),
      .rst(rst),
      .bus(ifB.slave)
   );

   // One comparison: counted, and reported as a failure if it does not match.
   task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                              input logic [XLEN-1:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Set every core-side input for the next cycle.
   task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0,
                                input logic [XLEN-1:0] v0, input logic e1,
                                input logic [AW-1:0] a1, input logic [XLEN-1:0] v1,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input logic cr);
      we0 = e0; wd0 = a0; d0 = v0;
      we1 = e1; wd1 = a1; d1 = v1;
      rd0 = r0; rd1 = r1; clrReq = cr;
   endtask

   // Expected read value: zero while clearing, zero for register 0 on the
   // hardwired instance, same-cycle write data on the bypass instance (load
   // port first), otherwise the stored value.
   function automatic logic [XLEN-1:0] expRead(input bit isA, input logic [AW-1:0] dir);
      if (!modelRunning) return '0;
      if (isA) begin
         if (dir == 0) return '0;
         if (!rst && we1 && wd1 == dir) return d1;
         if (!rst && we0 && wd0 == dir) return d0;
         return bankA[dir];
      end
      return bankB[dir];
   endfunction

   // Model of one rising edge. A clear takes NREGS uninterrupted edges and
   // leaves the whole bank zero; reset restarts it; in RUN the writes land
   // (load port last) and a ClearReq starts a fresh clear.
   task automatic modelEdge();
      if (rst) begin
         modelValid   = 1'b1;
         modelRunning = 1'b0;
         clearLeft    = NREGS;
      end else if (!modelValid) begin
         modelValid = 1'b0;
      end else if (!modelRunning) begin
         clearLeft--;
         if (clearLeft == 0) begin
            modelRunning = 1'b1;
            for (int i = 0; i < NREGS; i++) begin
               bankA[i] = '0;
               bankB[i] = '0;
            end
         end
      end else begin
         if (we0) begin
            if (wd0 != 0) bankA[wd0] = d0;
            bankB[wd0] = d0;
         end
         if (we1) begin
            if (wd1 != 0) bankA[wd1] = d1;
            bankB[wd1] = d1;
         end
         if (clrReq) begin
            modelRunning = 1'b0;
            clearLeft    = NREGS;
         end
      end
   endtask

   // Compare all outputs of both instances against the model.
   task automatic checkReads(input string tag);
      if (modelValid) begin
         checkOutput({tag, "/A.Ready"}, {31'b0, ifA.Ready}, {31'b0, modelRunning});
         checkOutput({tag, "/B.Ready"}, {31'b0, ifB.Ready}, {31'b0, modelRunning});
         checkOutput({tag, "/A.Read0"}, ifA.ReadData0, expRead(1'b1, rd0));
         checkOutput({tag, "/A.Read1"}, ifA.ReadData1, expRead(1'b1, rd1));
         checkOutput({tag, "/B.Read0"}, ifB.ReadData0, expRead(1'b0, rd0));
         checkOutput({tag, "/B.Read1"}, ifB.ReadData1, expRead(1'b0, rd1));
      end
   endtask

   // Check outputs mid-cycle, then advance one edge and update the model.
   task automatic step(input string tag);
      #1;
      checkReads(tag);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Read every register on both ports with no writes in flight.
   task automatic sweep(input string tag);
      we0 = 1'b0; we1 = 1'b0; clrReq = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         rd0 = AW'(r);
         rd1 = AW'(NREGS - 1 - r);
         #1;
         checkReads(tag);
      end
   endtask

   // Step until Ready rises, bounded; returns the number of edges taken.
   task automatic countClear(input string tag, output int n);
      n = 0;
      while (ifA.Ready !== 1'b1 && n < 100) begin
         step(tag);
         n++;
      end
   endtask

   int n;

   // Directed scenarios followed by a randomized phase and clear scenarios.
   initial begin
      $display("[TB] start");

      applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 0);
      rst = 1'b1;
      step("rst");
      step("rst");
      rst = 1'b0;
      countClear("resetClear", n);
      checkOutput("resetReadyEdges", n, 32);
      #1;
      checkOutput("firstWriteBypassA", ifA.ReadData0, 32'hDEADBEEF);
      checkOutput("firstWriteStoredB", ifB.ReadData0, 32'h0);
      step("firstWrite");
      sweep("afterFirstWrite");
      checkOutput("reg5A", bankA[5], 32'hDEADBEEF);
      rd0 = 5;
      #1;
      checkOutput("reg5ReadA", ifA.ReadData0, 32'hDEADBEEF);

      applyStimulus(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 7, 0);
      step("conflict");
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 7, 0);
      #1;
      checkOutput("conflictA", ifA.ReadData0, 32'h22222222);
      checkOutput("conflictB", ifB.ReadData1, 32'h22222222);

      applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
      #1;
      checkOutput("zeroBypassA", ifA.ReadData0, 32'h0);
      step("zeroWrite");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("zeroAfterA", ifA.ReadData0, 32'h0);
      checkOutput("plainReg0B", ifB.ReadData0, 32'hFFFFFFFF);

      applyStimulus(1, 3, 32'hA, 0, 0, 0, 0, 3, 0);
      step("bypassSetup");
      applyStimulus(1, 3, 32'hB, 0, 0, 0, 0, 3, 0);
      #1;
      checkOutput("bypassOnA", ifA.ReadData1, 32'hB);
      checkOutput("bypassOffB", ifB.ReadData1, 32'hA);
      step("bypassWrite");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
      #1;
      checkOutput("bypassAfterA", ifA.ReadData1, 32'hB);
      checkOutput("bypassAfterB", ifB.ReadData1, 32'hB);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                       XLEN'($urandom),
                       $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                       XLEN'($urandom),
                       ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                       AW'($urandom),
                       $urandom_range(0, 99) < 2);
         step("random");
      end

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      countClear("settle", n);
      for (int i = 1; i < NREGS; i++) begin
         applyStimulus(1, AW'(i), XLEN'(i), 0, 0, 0, AW'(i), 0, 0);
         step("fill");
      end
      sweep("filled");
      applyStimulus(0, 0, 0, 0, 0, 0, 9, 31, 1);
      step("clearReq");
      clrReq = 1'b0;
      countClear("softClear", n);
      checkOutput("softClearEdges", n, 32);
      sweep("afterSoftClear");

      applyStimulus(1, 4, 32'h44, 0, 0, 0, 4, 4, 0);
      step("refill");
      applyStimulus(0, 0, 0, 0, 0, 0, 4, 4, 1);
      step("clearReq2");
      clrReq = 1'b0;
      for (int i = 0; i < 10; i++) step("clearing");
      clrReq = 1'b1;
      step("lateClearReq");
      clrReq = 1'b0;
      countClear("noExtend", n);
      checkOutput("lateClearReqEdges", n, 21);
      sweep("afterNoExtend");

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("clearReq3");
      clrReq = 1'b0;
      for (int i = 0; i < 20; i++) step("clearing");
      rst = 1'b1;
      step("midClearRst");
      rst = 1'b0;
      countClear("restartClear", n);
      checkOutput("midClearResetEdges", n, 32);
      sweep("final");

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_dualwrite.md
Name: regfile_dualwrite

Overview:
- Parametrised successor to the core's single-write register file.
- Provides XLEN-wide, NREGS-deep storage with two synchronous write ports and two asynchronous read ports.
- Optional write-to-read bypass and an optional hardwired-zero register 0.
- A sequential clear engine zeroes the whole bank after reset or on request and reports readiness to the core.
- Sits between decode (read addresses) and writeback (ALU and load writeback ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREGS), address width; derived, not overridden.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- WriteEn0  in  1  write port 0 enable (ALU writeback).
- WriteDir0  in  AW  write port 0 address.
- WriteData0  in  XLEN  write port 0 data.
- WriteEn1  in  1  write port 1 enable (load writeback).
- WriteDir1  in  AW  write port 1 address.
- WriteData1  in  XLEN  write port 1 data.
- ReadDir0  in  AW  read port 0 address.
- ReadData0  out  XLEN  read port 0 data, combinational.
- ReadDir1  in  AW  read port 1 address.
- ReadData1  out  XLEN  read port 1 data, combinational.
- ClearReq  in  1  one-cycle request to re-zero the bank.
- Ready  out  1  1 = bank valid, writes accepted.

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- State machine has two states: CLEAR and RUN. A counter clr_cnt is AW bits wide.
- While rst = 1, at each edge: state <= CLEAR, clr_cnt <= 0, Ready = 0. Bank contents are not touched by rst itself.
- In CLEAR, at each edge: bank[clr_cnt] <= 0 and clr_cnt++. When clr_cnt == NREGS-1, state <= RUN.
- Ready is 1 exactly when state == RUN, so Ready rises at the NREGS-th edge after rst falls.
- In RUN, if ClearReq = 1 at an edge: state <= CLEAR, clr_cnt <= 0. Writes in that same cycle are still performed, then overwritten by the clear.
- ClearReq is ignored in CLEAR; it does not restart the counter.
- In CLEAR, both write ports are ignored (dropped, no queuing), and ReadData0/1 = 0 regardless of address or bypass.
- In RUN, if WriteEnN = 1 and the address is writable, bank[WriteDirN] <= WriteDataN at the edge.
  - Writable means: not (ZERO_REG = 1 and address == 0).
- Both write ports to the same address in one cycle: port 1 (load) wins; port 0's data is discarded.
- Reads are asynchronous: ReadDataK = bank[ReadDirK] with zero latency.
- ZERO_REG = 1 and ReadDirK == 0: ReadDataK = 0 always.
- BYPASS = 1, in RUN, ReadDirK matching an enabled, writable WriteDirN in the same cycle: ReadDataK = WriteDataN.
  - Port 1 has priority if both ports match.
  - Bypass path is combinational from write inputs to read outputs.
- BYPASS = 0: reads return the pre-edge stored value; the new value is visible the cycle after the edge.
- Read ports are independent; identical addresses on both read ports are legal.
- Address range: NREGS is a power of two, so every AW-bit address is valid; there is no out-of-range case.
- rst asserted mid-CLEAR restarts the clear from register 0. rst asserted in RUN drops writes in that cycle.
- Total RTL scope: bank, clear FSM/counter, write arbitration, bypass muxes — target 150–250 lines.

Test Plan:
- Reset sequence, NREGS=32: pulse rst for 2 cycles, then drive WriteEn0=1, WriteDir0=5, WriteData0=0xDEADBEEF every cycle -> Ready=0 for 32 edges after rst falls, 1 after; register 5 reads 0xDEADBEEF only from writes issued once Ready=1. All registers read 0 before the first accepted write.
- Dual-write conflict: both ports to register 7, port0 data 0x11111111, port1 data 0x22222222 -> register 7 reads 0x22222222 the next cycle.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to register 0 on both ports -> ReadData0 with ReadDir0=0 stays 0, including the same-cycle bypass case.
- Bypass, BYPASS=1: register 3 holds 0xA; same cycle write 0xB to register 3 on port 0 with ReadDir1=3 -> ReadData1 = 0xB before the edge. Repeat with BYPASS=0 -> 0xA before the edge, 0xB after.
- Soft clear: fill registers 1–31 with their index values, assert ClearReq for 1 cycle -> Ready=0 for 32 cycles, reads return 0 during the clear, all registers 0 afterwards. A second ClearReq at clear cycle 10 does not extend the clear.
- Reset mid-clear: assert rst at clear cycle 20 -> counter restarts; Ready rises 32 edges after rst falls.
